// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory bus between instruction fetch and data access,
// alternating grants under contention and aborting transfers that exceed TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        imem_ack_n,
  output logic [31:0] i_rdata,
  output logic        i_err,
  output logic        dmem_ack_n,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack_n
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [1:0] SIZE_WORD   = 2'b10;

  logic [1:0]  r_state;
  logic        r_lastGrant;
  logic [7:0]  r_waitCnt;
  logic        r_busReq;
  logic        r_busWe;
  logic [1:0]  r_busSize;
  logic [31:0] r_busAddr;
  logic [31:0] r_busWdata;

  logic w_grantI;
  logic w_grantD;
  logic w_busDone;
  logic w_timeout;
  logic w_finish;
  logic w_pickD;

  assign w_grantI  = (r_state == GRANT_I);
  assign w_grantD  = (r_state == GRANT_D);
  assign w_busDone = ~bus_ack_n;
  assign w_timeout = (r_waitCnt == TIMEOUT_CNT) & bus_ack_n;
  assign w_finish  = w_busDone | w_timeout;
  // On a tie the data side wins only if fetch was served last.
  assign w_pickD   = d_req & (~i_req | (r_lastGrant == LAST_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= LAST_I;
      r_waitCnt   <= 8'd0;
      r_busReq    <= 1'b0;
      r_busWe     <= 1'b0;
      r_busSize   <= 2'b00;
      r_busAddr   <= 32'd0;
      r_busWdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickD) begin
            r_state    <= GRANT_D;
            r_busReq   <= 1'b1;
            r_busWe    <= d_we;
            r_busSize  <= d_size;
            r_busAddr  <= d_addr;
            r_busWdata <= d_wdata;
            r_waitCnt  <= 8'd0;
          end else if (i_req) begin
            r_state    <= GRANT_I;
            r_busReq   <= 1'b1;
            r_busWe    <= 1'b0;
            r_busSize  <= SIZE_WORD;
            r_busAddr  <= i_addr;
            r_busWdata <= 32'd0;
            r_waitCnt  <= 8'd0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (w_finish) begin
            r_state     <= IDLE;
            r_busReq    <= 1'b0;
            r_lastGrant <= w_grantD ? LAST_D : LAST_I;
          end else if (r_waitCnt != TIMEOUT_CNT) begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_busReq <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = r_busReq;
  assign bus_we    = r_busWe;
  assign bus_size  = r_busSize;
  assign bus_addr  = r_busAddr;
  assign bus_wdata = r_busWdata;

  // An idle requester always sees ack so its pipeline never stalls.
  assign imem_ack_n = ~(~i_req | (w_grantI & w_finish));
  assign dmem_ack_n = ~(~d_req | (w_grantD & w_finish));

  assign i_rdata = (w_grantI & w_busDone) ? bus_rdata : 32'd0;
  assign d_rdata = (w_grantD & w_busDone) ? bus_rdata : 32'd0;

  assign i_err = w_grantI & w_timeout;
  assign d_err = w_grantD & w_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a wait-state memory responder plus a completion
// scoreboard that checks each acknowledged transfer and the grant order.
module tb_mem_arbiter;

  localparam logic [31:0] RDATA_MASK = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        imem_ack_n;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        dmem_ack_n;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        bus_req;
  logic        bus_we;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack_n = 1'b1;

  int checks = 0;
  int failures = 0;
  int waitStates = 0;
  int respCnt = 0;
  bit stuckAck = 1'b0;
  bit idleAckLow = 1'b0;

  txn_t iQ[$];
  txn_t dQ[$];
  bit   orderQ[$];

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .imem_ack_n (imem_ack_n),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .dmem_ack_n (dmem_ack_n),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_size   (bus_size),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack_n  (bus_ack_n)
  );

  always #5 clk = ~clk;

  assign bus_rdata = bus_addr ^ RDATA_MASK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [1:0] dSize,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_size  = dSize;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic expectTxn(input bit isData, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic [31:0] wdata, input logic err);
    txn_t t;
    t.addr  = addr;
    t.we    = we;
    t.size  = size;
    t.wdata = wdata;
    t.rdata = err ? 32'd0 : (addr ^ RDATA_MASK);
    t.err   = err;
    if (isData) dQ.push_back(t);
    else iQ.push_back(t);
    orderQ.push_back(isData);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after waitStates cycles of each bus request, or never when stuck.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_req) begin
        bus_ack_n = (!stuckAck && respCnt == waitStates) ? 1'b0 : 1'b1;
        respCnt++;
      end else begin
        respCnt = 0;
        bus_ack_n = idleAckLow ? 1'b0 : 1'b1;
      end
    end
  end

  // Every acknowledged request retires the oldest expected transfer for that side.
  always @(negedge clk) begin
    txn_t e;
    bit side;
    if (i_req && !imem_ack_n) begin
      checkOutput("iAckExpected", 32'(iQ.size() != 0), 32'd1);
      if (iQ.size() != 0) begin
        e = iQ.pop_front();
        checkOutput("iBusAddr", bus_addr, e.addr);
        checkOutput("iBusWe", bus_we, e.we);
        checkOutput("iBusSize", bus_size, e.size);
        checkOutput("iRdata", i_rdata, e.rdata);
        checkOutput("iErr", i_err, e.err);
      end
      side = (orderQ.size() != 0) ? orderQ.pop_front() : 1'b1;
      checkOutput("grantOrderI", 32'(side), 32'd0);
    end
    if (d_req && !dmem_ack_n) begin
      checkOutput("dAckExpected", 32'(dQ.size() != 0), 32'd1);
      if (dQ.size() != 0) begin
        e = dQ.pop_front();
        checkOutput("dBusAddr", bus_addr, e.addr);
        checkOutput("dBusWe", bus_we, e.we);
        checkOutput("dBusSize", bus_size, e.size);
        checkOutput("dBusWdata", bus_wdata, e.wdata);
        checkOutput("dRdata", d_rdata, e.rdata);
        checkOutput("dErr", d_err, e.err);
      end
      side = (orderQ.size() != 0) ? orderQ.pop_front() : 1'b0;
      checkOutput("grantOrderD", 32'(side), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    tick;
    tick;

    @(negedge clk);
    checkOutput("rstBusReq", bus_req, 1'b0);
    checkOutput("rstBusWe", bus_we, 1'b0);
    checkOutput("rstBusSize", bus_size, 2'b00);
    checkOutput("rstBusAddr", bus_addr, 32'd0);
    checkOutput("rstBusWdata", bus_wdata, 32'd0);
    checkOutput("rstImemAckIdle", imem_ack_n, 1'b0);
    checkOutput("rstDmemAckIdle", dmem_ack_n, 1'b0);
    checkOutput("rstIRdata", i_rdata, 32'd0);
    checkOutput("rstDRdata", d_rdata, 32'd0);
    checkOutput("rstIErr", i_err, 1'b0);
    checkOutput("rstDErr", d_err, 1'b0);
    tick;
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("rstImemAckReq", imem_ack_n, 1'b1);
    checkOutput("rstBusReqHeld", bus_req, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick;
    tick;

    // Single fetch against zero-wait memory.
    expectTxn(1'b0, 32'h0000_0100, 1'b0, 2'b10, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("fetchIdleAck", imem_ack_n, 1'b1);
    checkOutput("fetchIdleBusReq", bus_req, 1'b0);
    checkOutput("fetchIdleDmem", dmem_ack_n, 1'b0);
    tick;
    @(negedge clk);
    checkOutput("fetchBusReq", bus_req, 1'b1);
    checkOutput("fetchBusAddr", bus_addr, 32'h0000_0100);
    checkOutput("fetchBusWe", bus_we, 1'b0);
    checkOutput("fetchImemAck", imem_ack_n, 1'b0);
    checkOutput("fetchDmemAck", dmem_ack_n, 1'b0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("fetchDoneBusReq", bus_req, 1'b0);
    checkOutput("fetchDoneDmem", dmem_ack_n, 1'b0);
    tick;

    // Continuous contention: last grant was fetch, so data goes first.
    expectTxn(1'b1, 32'h0000_3000, 1'b0, 2'b10, 32'h0000_1234, 1'b0);
    expectTxn(1'b0, 32'h0000_0200, 1'b0, 2'b10, 32'd0, 1'b0);
    expectTxn(1'b1, 32'h0000_3000, 1'b0, 2'b10, 32'h0000_1234, 1'b0);
    expectTxn(1'b0, 32'h0000_0200, 1'b0, 2'b10, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0000_1234);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("altImemAck", imem_ack_n, (c % 4 == 3) ? 32'd0 : 32'd1);
      checkOutput("altDmemAck", dmem_ack_n, (c % 4 == 1) ? 32'd0 : 32'd1);
      tick;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    tick;

    // Byte store with three wait states; requester inputs change mid-grant.
    waitStates = 3;
    expectTxn(1'b1, 32'h0000_2003, 1'b1, 2'b00, 32'h0000_00AB, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00AB);
    @(negedge clk);
    checkOutput("waitIdleDmem", dmem_ack_n, 1'b1);
    tick;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("waitBusReq", bus_req, 1'b1);
      checkOutput("waitBusAddr", bus_addr, 32'h0000_2003);
      checkOutput("waitBusWe", bus_we, 1'b1);
      checkOutput("waitBusSize", bus_size, 2'b00);
      checkOutput("waitBusWdata", bus_wdata, 32'h0000_00AB);
      checkOutput("waitDmemAck", dmem_ack_n, (j == 3) ? 32'd0 : 32'd1);
      tick;
      if (j == 0) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'hDEAD_0000, 32'h0000_FFFF);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("waitDoneBusReq", bus_req, 1'b0);
    tick;

    // Memory never answers: abort on the fifth grant cycle with TIMEOUT=4.
    stuckAck = 1'b1;
    expectTxn(1'b1, 32'h0000_4000, 1'b0, 2'b10, 32'h0000_5555, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0000_5555);
    tick;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput("toBusReq", bus_req, 1'b1);
      checkOutput("toDmemAck", dmem_ack_n, (j == 4) ? 32'd0 : 32'd1);
      checkOutput("toDErr", d_err, (j == 4) ? 32'd1 : 32'd0);
      tick;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    stuckAck = 1'b0;
    @(negedge clk);
    checkOutput("toDoneBusReq", bus_req, 1'b0);
    checkOutput("toDoneDErr", d_err, 1'b0);
    tick;

    // Reset in the middle of a fetch grant, then a clean restart.
    expectTxn(1'b0, 32'h0000_0500, 1'b0, 2'b10, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    tick;
    @(negedge clk);
    checkOutput("midGrantBusReq", bus_req, 1'b1);
    checkOutput("midGrantImem", imem_ack_n, 1'b1);
    tick;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusReq", bus_req, 1'b0);
    checkOutput("midRstImemAck", imem_ack_n, 1'b1);
    checkOutput("midRstIErr", i_err, 1'b0);
    checkOutput("midRstIRdata", i_rdata, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstIdle", bus_req, 1'b0);
    tick;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("restartBusReq", bus_req, 1'b1);
      checkOutput("restartImemAck", imem_ack_n, (j == 3) ? 32'd0 : 32'd1);
      checkOutput("restartIErr", i_err, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("restartDoneBusReq", bus_req, 1'b0);
    tick;

    // Stray bus acknowledge with nobody requesting.
    idleAckLow = 1'b1;
    tick;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("strayImemAck", imem_ack_n, 1'b0);
      checkOutput("strayDmemAck", dmem_ack_n, 1'b0);
      checkOutput("strayBusReq", bus_req, 1'b0);
      checkOutput("strayIErr", i_err, 1'b0);
      checkOutput("strayDErr", d_err, 1'b0);
      checkOutput("strayIRdata", i_rdata, 32'd0);
      checkOutput("strayDRdata", d_rdata, 32'd0);
      tick;
    end
    idleAckLow = 1'b0;
    tick;

    checkOutput("iQueueDrained", 32'(iQ.size()), 32'd0);
    checkOutput("dQueueDrained", 32'(dQ.size()), 32'd0);
    checkOutput("orderQueueDrained", 32'(orderQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
